memory_port_arbiter: RTL and testbench

Shares the single 20-bit memory port of the pipelined processor between the instruction-fetch stage and the memory-access stage. Each requester holds a level request until it sees a one-cycle valid pulse. The arbiter grants one access at a time and drives registered memory-port signals. It tracks a configurable memory read latency and produces per-stage stall signals for the hazard and stall logic. MEM has priority; a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/memory_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Purpose : shares one registered memory port between instruction fetch (IF) and the memory stage (MEM).
// Latency : read = request cycle t, ReadEnable t+1, Valid t+MEM_LATENCY+1; write = WriteEnable t+1, Valid t+2.
// Backpr. : one access in flight; losers see Stall_* until Valid. MEM has priority, starve counter forces IF.
//
// Ports:
//   Clock, Reset                      rising-edge clock, synchronous active-low reset
//   IF_Req/IF_Address                 fetch request (read only), level until IF_Valid
//   IF_Valid/IF_Data                  one-cycle completion pulse, held fetch data
//   MEM_Req/MEM_WriteEnable/
//   MEM_Address/MEM_WriteData         memory-stage request, level until MEM_Valid
//   MEM_Valid/MEM_ReadData            one-cycle completion pulse, held load data
//   Stall_IF/Stall_MEM                Req & ~Valid per stage
//   Ram_*                             registered memory port, Ram_ReadData returns MEM_LATENCY cycles later
module memory_port_arbiter #(
    parameter int DATA_WIDTH   = 20,
    parameter int ADDR_WIDTH   = 20,
    parameter int MEM_LATENCY  = 1,   // 1..7, fits the 3-bit latency counter
    parameter int STARVE_LIMIT = 4    // 1..15, fits the 4-bit starvation counter
) (
    input  logic                  Clock,
    input  logic                  Reset,

    input  logic                  IF_Req,
    input  logic [ADDR_WIDTH-1:0] IF_Address,
    output logic                  IF_Valid,
    output logic [DATA_WIDTH-1:0] IF_Data,

    input  logic                  MEM_Req,
    input  logic                  MEM_WriteEnable,
    input  logic [ADDR_WIDTH-1:0] MEM_Address,
    input  logic [DATA_WIDTH-1:0] MEM_WriteData,
    output logic                  MEM_Valid,
    output logic [DATA_WIDTH-1:0] MEM_ReadData,

    output logic                  Stall_IF,
    output logic                  Stall_MEM,

    output logic [ADDR_WIDTH-1:0] Ram_Address,
    output logic [DATA_WIDTH-1:0] Ram_WriteData,
    output logic                  Ram_WriteEnable,
    output logic                  Ram_ReadEnable,
    input  logic [DATA_WIDTH-1:0] Ram_ReadData
);

    // WRITE_ISSUE is the single write-enable cycle; a write then goes
    // straight to DONE without passing through the read latency counter.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_ISSUE = 2'd1,
        READ_WAIT   = 2'd2,
        DONE        = 2'd3
    } state_e;

    localparam logic [2:0] LAT_LOAD  = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MX = 4'(STARVE_LIMIT);

    state_e                state_q,     state_d;
    logic [2:0]            lat_cnt_q,   lat_cnt_d;
    logic [3:0]            starve_q,    starve_d;
    logic                  owner_if_q,  owner_if_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q,    ram_we_d;
    logic                  ram_re_q,    ram_re_d;
    logic [DATA_WIDTH-1:0] if_data_q,   if_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

    logic if_valid;
    logic mem_valid;
    logic if_elig;
    logic mem_elig;
    logic can_arb;
    logic grant_if;
    logic grant_mem;

    // Valid is a pure decode of the DONE state, so reset clears it with the FSM.
    assign if_valid  = (state_q == DONE) &&  owner_if_q;
    assign mem_valid = (state_q == DONE) && !owner_if_q;

    // A requester still holds Req during its own Valid cycle; masking it
    // there keeps that completed request from being issued a second time.
    assign if_elig  = IF_Req  && !if_valid;
    assign mem_elig = MEM_Req && !mem_valid;

    // Arbitrate when the port is free: idle, or the completion cycle (back-to-back).
    assign can_arb   = (state_q == IDLE) || (state_q == DONE);
    assign grant_if  = can_arb && if_elig && (!mem_elig || (starve_q == STARVE_MX));
    assign grant_mem = can_arb && mem_elig && !grant_if;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        starve_d    = starve_q;
        owner_if_d  = owner_if_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WRITE_ISSUE: begin
                state_d = DONE;
            end
            READ_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    // Capture into the owner's register only; the other
                    // requester's data is left untouched.
                    if (owner_if_q) begin
                        if_data_d = Ram_ReadData;
                    end else begin
                        mem_rdata_d = Ram_ReadData;
                    end
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new grant overrides the DONE -> IDLE step above.
        if (grant_if || grant_mem) begin
            owner_if_d = grant_if;
            ram_addr_d = grant_if ? IF_Address : MEM_Address;
            if (grant_mem && MEM_WriteEnable) begin
                ram_wdata_d = MEM_WriteData;
                ram_we_d    = 1'b1;
                state_d     = WRITE_ISSUE;
            end else begin
                ram_re_d  = 1'b1;
                lat_cnt_d = LAT_LOAD;
                state_d   = READ_WAIT;
            end
        end

        // Counts MEM wins over a waiting IF; any gap in IF_Req restarts the count.
        if (!IF_Req || grant_if) begin
            starve_d = 4'd0;
        end else if (grant_mem && if_elig && (starve_q != STARVE_MX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 3'd0;
            starve_q    <= 4'd0;
            owner_if_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            starve_q    <= starve_d;
            owner_if_q  <= owner_if_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign IF_Valid        = if_valid;
    assign MEM_Valid       = mem_valid;
    assign IF_Data         = if_data_q;
    assign MEM_ReadData    = mem_rdata_q;
    assign Stall_IF        = IF_Req  && !if_valid;
    assign Stall_MEM       = MEM_Req && !mem_valid;
    assign Ram_Address     = ram_addr_q;
    assign Ram_WriteData   = ram_wdata_q;
    assign Ram_WriteEnable = ram_we_q;
    assign Ram_ReadEnable  = ram_re_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Purpose : randomized check of memory_port_arbiter against a transaction-timestamp reference model.
// Latency : checks every output every cycle, sampled on the falling edge.
// Backpr. : requesters hold Req until Valid, then continue, drop, or abort at random rates.
module tb_memory_port_arbiter;

    localparam int DW   = 20;
    localparam int AW   = 20;
    localparam int LAT  = 3;
    localparam int SLIM = 2;
    localparam int NCYC = 3000;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          IF_Req;
    logic [AW-1:0] IF_Address;
    logic          IF_Valid;
    logic [DW-1:0] IF_Data;
    logic          MEM_Req;
    logic          MEM_WriteEnable;
    logic [AW-1:0] MEM_Address;
    logic [DW-1:0] MEM_WriteData;
    logic          MEM_Valid;
    logic [DW-1:0] MEM_ReadData;
    logic          Stall_IF;
    logic          Stall_MEM;
    logic [AW-1:0] Ram_Address;
    logic [DW-1:0] Ram_WriteData;
    logic          Ram_WriteEnable;
    logic          Ram_ReadEnable;
    logic [DW-1:0] Ram_ReadData;

    memory_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(SLIM)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .IF_Req         (IF_Req),
        .IF_Address     (IF_Address),
        .IF_Valid       (IF_Valid),
        .IF_Data        (IF_Data),
        .MEM_Req        (MEM_Req),
        .MEM_WriteEnable(MEM_WriteEnable),
        .MEM_Address    (MEM_Address),
        .MEM_WriteData  (MEM_WriteData),
        .MEM_Valid      (MEM_Valid),
        .MEM_ReadData   (MEM_ReadData),
        .Stall_IF       (Stall_IF),
        .Stall_MEM      (Stall_MEM),
        .Ram_Address    (Ram_Address),
        .Ram_WriteData  (Ram_WriteData),
        .Ram_WriteEnable(Ram_WriteEnable),
        .Ram_ReadEnable (Ram_ReadEnable),
        .Ram_ReadData   (Ram_ReadData)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: the access in flight is described by its grant cycle
    // and the cycle its Valid is due; every port event is a fixed offset.
    bit            m_busy;
    bit            m_own_if;
    bit            m_wr;
    int            m_gnt;
    int            m_end;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] e_if_data;
    logic [DW-1:0] e_mem_rdata;
    logic [AW-1:0] e_ram_addr;
    int            starve;
    int            n_if_grants;
    int            n_mem_grants;
    logic [DW-1:0] mem_img [logic [AW-1:0]];

    function automatic logic [DW-1:0] ram_lookup(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (mem_img.exists(a)) begin
            v = mem_img[a];
        end else begin
            v = {a[9:0], ~a[9:0]};
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic model_reset();
        m_busy      = 1'b0;
        e_if_data   = '0;
        e_mem_rdata = '0;
        e_ram_addr  = '0;
        starve      = 0;
    endtask

    task automatic model_step(input int n, input bit do_check);
        bit exp_ren, exp_wen, exp_ifv, exp_memv;
        bit if_el, mem_el, g_if, g_mem;
        exp_ren  = m_busy && !m_wr && (n == m_gnt + 1);
        exp_wen  = m_busy &&  m_wr && (n == m_gnt + 1);
        exp_ifv  = m_busy &&  m_own_if && (n == m_end);
        exp_memv = m_busy && !m_own_if && (n == m_end);
        if (exp_ifv  && !m_wr) e_if_data   = m_rdata;
        if (exp_memv && !m_wr) e_mem_rdata = m_rdata;

        if (do_check) begin
            check_eq("ram_re",    32'(Ram_ReadEnable),  32'(exp_ren));
            check_eq("ram_we",    32'(Ram_WriteEnable), 32'(exp_wen));
            check_eq("if_valid",  32'(IF_Valid),        32'(exp_ifv));
            check_eq("mem_valid", 32'(MEM_Valid),       32'(exp_memv));
            check_eq("if_data",   32'(IF_Data),         32'(e_if_data));
            check_eq("mem_rdata", 32'(MEM_ReadData),    32'(e_mem_rdata));
            check_eq("ram_addr",  32'(Ram_Address),     32'(e_ram_addr));
            check_eq("stall_if",  32'(Stall_IF),        32'(IF_Req && !exp_ifv));
            check_eq("stall_mem", 32'(Stall_MEM),       32'(MEM_Req && !exp_memv));
            if (exp_wen) check_eq("ram_wdata", 32'(Ram_WriteData), 32'(m_wdata));
        end

        if (!Reset) begin
            model_reset();
            return;
        end

        if_el  = IF_Req  && !exp_ifv;
        mem_el = MEM_Req && !exp_memv;
        g_if   = 1'b0;
        g_mem  = 1'b0;
        if (!m_busy || (n == m_end)) begin
            m_busy = 1'b0;
            g_if   = if_el && (!mem_el || (starve == SLIM));
            g_mem  = mem_el && !g_if;
        end

        if (!IF_Req || g_if) starve = 0;
        else if (g_mem && if_el && starve < SLIM) starve++;

        if (g_if || g_mem) begin
            m_busy     = 1'b1;
            m_own_if   = g_if;
            m_wr       = g_mem && MEM_WriteEnable;
            m_gnt      = n;
            m_addr     = g_if ? IF_Address : MEM_Address;
            e_ram_addr = m_addr;
            m_end      = m_wr ? n + 2 : n + LAT + 1;
            if (m_wr) begin
                m_wdata         = MEM_WriteData;
                mem_img[m_addr] = MEM_WriteData;
            end else begin
                m_rdata = ram_lookup(m_addr);
            end
            if (g_if) n_if_grants++;
            else      n_mem_grants++;
        end
    endtask

    int unsigned p_new, p_cont, p_abort;
    bit          last_ifv, last_memv;

    initial begin
        Reset           = 1'b0;
        IF_Req          = 1'b1;
        IF_Address      = 20'h00010;
        MEM_Req         = 1'b1;
        MEM_WriteEnable = 1'b0;
        MEM_Address     = 20'h00040;
        MEM_WriteData   = '0;
        Ram_ReadData    = '0;
        last_ifv        = 1'b0;
        last_memv       = 1'b0;
        n_if_grants     = 0;
        n_mem_grants    = 0;
        mem_img[20'h00010] = 20'hABCDE;
        model_reset();

        for (int n = 0; n < NCYC; n++) begin
            @(posedge Clock);
            #1;
            if (n < 3) begin
                // Reset held with both requests up: the port must stay quiet.
                Reset = 1'b0;
            end else begin
                Reset = 1'b1;
                if (n < 30)      begin p_new = 0;  p_cont = 0;   p_abort = 0; end
                else if (n < 80) begin p_new = 100; p_cont = 100; p_abort = 0; end
                else             begin p_new = 40; p_cont = 50;  p_abort = 4; end
                if (n >= 80 && $urandom_range(0, 99) < 2) Reset = 1'b0;

                if (IF_Req) begin
                    if (last_ifv) begin
                        if ($urandom_range(0, 99) < p_cont) IF_Address = rand_addr();
                        else                                IF_Req = 1'b0;
                    end else if ($urandom_range(0, 99) < p_abort) begin
                        IF_Req = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < p_new) begin
                    IF_Req     = 1'b1;
                    IF_Address = rand_addr();
                end

                if (MEM_Req) begin
                    if (last_memv) begin
                        if ($urandom_range(0, 99) < p_cont) begin
                            MEM_Address     = rand_addr();
                            MEM_WriteEnable = (n >= 80) ? 1'($urandom_range(0, 1)) : 1'b0;
                            MEM_WriteData   = DW'($urandom);
                        end else begin
                            MEM_Req = 1'b0;
                        end
                    end else if ($urandom_range(0, 99) < p_abort) begin
                        MEM_Req = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < p_new) begin
                    MEM_Req         = 1'b1;
                    MEM_Address     = rand_addr();
                    MEM_WriteEnable = (n >= 80) ? 1'($urandom_range(0, 1)) : 1'b0;
                    MEM_WriteData   = DW'($urandom);
                end

                if (n == 20) begin
                    MEM_Req         = 1'b1;
                    MEM_WriteEnable = 1'b1;
                    MEM_Address     = 20'h00200;
                    MEM_WriteData   = 20'h12345;
                end
                if (n == 30) begin
                    IF_Req          = 1'b1;
                    IF_Address      = 20'h00010;
                    MEM_Req         = 1'b1;
                    MEM_WriteEnable = 1'b0;
                    MEM_Address     = 20'h00200;
                end
            end

            // Return read data only in the one cycle the arbiter should sample it.
            if (m_busy && !m_wr && (n == m_gnt + LAT)) Ram_ReadData = m_rdata;
            else                                       Ram_ReadData = DW'($urandom);

            @(negedge Clock);
            model_step(n, n >= 1);
            last_ifv  = IF_Valid;
            last_memv = MEM_Valid;
        end

        // Both requesters must have been served repeatedly.
        check_eq("if_served",  32'(n_if_grants  > 20), 32'd1);
        check_eq("mem_served", 32'(n_mem_grants > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
